// File: rtl/local_average_unpack.sv
// Unpacks {sof, average, pixel} words into positioned output beats behind a 2-entry skid buffer.
// Optional macro LOCAL_AVERAGE_UNPACK_BINARIZE_EN enables the pixel > average binarized output.
module local_average_unpack #(
    parameter int FRAME_WIDTH = 768,
    parameter int FRAME_LINES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_pixel,
    output logic [7:0]  out_avg,
    output logic        out_bin,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [9:0] X_LAST = 10'(FRAME_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(FRAME_LINES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [16:0] r_buf [2];
    logic [1:0]  r_cnt;
    logic        r_in_ready;
    logic [9:0]  r_x;
    logic [8:0]  r_y;

    logic [7:0]  r_pixel;
    logic [7:0]  r_avg;
    logic [9:0]  r_bx;
    logic [8:0]  r_by;
    logic        r_sof;
    logic        r_eol;
    logic        r_last;
    logic        r_valid;
    logic        r_err;

    logic        w_accept;
    logic        w_head_valid;
    logic [16:0] w_head;
    logic        w_flag;
    logic        w_discard;
    logic        w_consume;
    logic        w_emit;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;
    logic [1:0]  w_cnt_next;

    logic [9:0]  w_bx;
    logic [8:0]  w_by;
    logic        w_err;
    logic        w_last;
    logic [9:0]  w_nx;
    logic [8:0]  w_ny;

    // The oldest word is the buffer head, or the incoming word itself when the buffer is empty.
    assign w_accept     = in_valid && r_in_ready;
    assign w_head_valid = (r_cnt != 2'd0) || w_accept;
    assign w_head       = (r_cnt != 2'd0) ? r_buf[0] : in_data;
    assign w_flag       = w_head[16];
    assign w_discard    = (r_state == WAIT_SOF) && !w_flag;
    assign w_consume    = w_head_valid && (w_discard || !r_valid || out_ready);
    assign w_emit       = w_consume && !w_discard;
    assign w_pop        = w_consume && (r_cnt != 2'd0);
    assign w_push       = w_accept && !((r_cnt == 2'd0) && w_consume);
    assign w_wr_idx     = w_pop ? (r_cnt == 2'd2) : (r_cnt == 2'd1);
    assign w_cnt_next   = r_cnt - {1'b0, w_pop} + {1'b0, w_push};

    always_ff @(posedge clk) begin
        if (w_pop) r_buf[0] <= r_buf[1];
        if (w_push) r_buf[w_wr_idx] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_next;
            r_in_ready <= (w_cnt_next <= 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= WAIT_SOF;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_emit) w_state_next = w_last ? WAIT_SOF : ACTIVE;
    end

    // A flag word always restarts at (0,0); it is only an error if (0,0) was not expected next.
    always_comb begin
        w_bx  = r_x;
        w_by  = r_y;
        w_err = 1'b0;
        if (w_flag) begin
            w_bx  = 10'd0;
            w_by  = 9'd0;
            w_err = (r_state == ACTIVE) && ((r_x != 10'd0) || (r_y != 9'd0));
        end
        w_last = (w_bx == X_LAST) && (w_by == Y_LAST);
        if (w_bx == X_LAST) begin
            w_nx = 10'd0;
            w_ny = w_last ? 9'd0 : w_by + 9'd1;
        end else begin
            w_nx = w_bx + 10'd1;
            w_ny = w_by;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= 10'd0;
            r_y <= 9'd0;
        end else if (w_emit) begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel <= 8'd0;
            r_avg   <= 8'd0;
            r_bx    <= 10'd0;
            r_by    <= 9'd0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_emit && w_err;
            if (w_emit) begin
                r_pixel <= w_head[7:0];
                r_avg   <= w_head[15:8];
                r_bx    <= w_bx;
                r_by    <= w_by;
                r_sof   <= (w_bx == 10'd0) && (w_by == 9'd0);
                r_eol   <= (w_bx == X_LAST);
                r_last  <= w_last;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef LOCAL_AVERAGE_UNPACK_BINARIZE_EN
    logic r_bin;

    always_ff @(posedge clk) begin
        if (reset)       r_bin <= 1'b0;
        else if (w_emit) r_bin <= (w_head[7:0] > w_head[15:8]);
    end

    assign out_bin = r_bin;
`else
    assign out_bin = 1'b0;
`endif

    assign in_ready   = r_in_ready;
    assign out_pixel  = r_pixel;
    assign out_avg    = r_avg;
    assign out_x      = r_bx;
    assign out_y      = r_by;
    assign out_sof    = r_sof;
    assign out_eol    = r_eol;
    assign out_valid  = r_valid;
    assign frame_done = r_valid && out_ready && r_last;
    assign frame_err  = r_err;

endmodule

// File: doc/local_average_unpack.md
LOCAL_AVERAGE_UNPACK -- requirements
Module: local_average_unpack

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 768: pixels per line.
REQ-002 SHALL have parameter FRAME_LINES, default 480: lines per frame.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  17  packed word: [16] start-of-frame flag, [15:8] local average, [7:0] pixel.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port out_pixel  output  8  unpacked pixel.
REQ-009 SHALL have port out_avg  output  8  unpacked local average.
REQ-010 SHALL have port out_bin  output  1  binarized pixel.
REQ-011 SHALL have port out_x  output  10  column of the output beat.
REQ-012 SHALL have port out_y  output  9  line of the output beat.
REQ-013 SHALL have port out_sof  output  1  beat is pixel (0,0).
REQ-014 SHALL have port out_eol  output  1  beat is the last pixel of a line.
REQ-015 SHALL have port out_valid  output  1  output beat valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse, last pixel of a frame left the block.
REQ-018 SHALL have port frame_err  output  1  one-cycle pulse, SOF received mid-frame.

Function
REQ-019 SHALL accept a word when in_valid && in_ready; SHALL ignore in_data otherwise.
REQ-020 SHALL buffer accepted words in a 2-entry skid buffer; in_ready SHALL be a register, high when at most one entry is occupied.
REQ-021 SHALL present an accepted word on the outputs 1 cycle after acceptance when the buffer is empty and out_ready is high.
REQ-022 SHALL hold all out_* stable while out_valid && !out_ready; SHALL never drop or duplicate an accepted word.
REQ-023 SHALL implement states WAIT_SOF and ACTIVE.
REQ-024 In WAIT_SOF, accepted words with flag 0 SHALL be consumed and discarded (no output beat).
REQ-025 In WAIT_SOF, a word with flag 1 SHALL become beat (0,0) with out_sof=1 and move the FSM to ACTIVE.
REQ-026 In ACTIVE, x SHALL increment per word, wrap to 0 at FRAME_WIDTH-1 with y incremented; out_eol=1 when x=FRAME_WIDTH-1.
REQ-027 Beat (FRAME_WIDTH-1, FRAME_LINES-1) SHALL assert frame_done in the cycle it handshakes out and return FSM to WAIT_SOF.
REQ-028 A flag-1 word in ACTIVE at any position other than (0,0) SHALL pulse frame_err, be emitted as (0,0) with out_sof=1, and restart counting.
REQ-029 A flag-1 word that is simultaneously the expected (0,0) SHALL not raise frame_err.
REQ-030 out_pixel=in_data[7:0], out_avg=in_data[15:8] unchanged; out_x/out_y unsigned, no saturation.

Reset
REQ-031 On reset: FSM=WAIT_SOF, buffer empty, x=y=0, in_ready=1, out_valid=0, frame_done=0, frame_err=0, all other outputs 0.
REQ-032 Reset mid-frame SHALL discard buffered words; first post-reset beat requires a new flag-1 word.

Configuration
REQ-033 With macro LOCAL_AVERAGE_UNPACK_BINARIZE_EN defined, out_bin SHALL be 1 iff pixel > average (unsigned, strict; equal gives 0).
REQ-034 Without LOCAL_AVERAGE_UNPACK_BINARIZE_EN, out_bin SHALL be constant 0 and no comparator SHALL be synthesized; all else unchanged.

Verification
REQ-035 Reset, then 3 words flag 0, then 0x1_80_40 -> first three discarded; beat x=0,y=0, sof=1, avg=0x80, pixel=0x40, bin=0.
REQ-036 Full 768x480 frame, out_ready=1 -> 368640 beats, eol on every x=767, frame_done once with (767,479), FSM back to WAIT_SOF.
REQ-037 out_ready low 10 cycles mid-line with in_valid high -> in_ready drops after 2 words, output held stable, no loss; order preserved on release.
REQ-038 Flag-1 word at (100,5) -> frame_err pulse 1 cycle, that beat out as (0,0) sof=1, next beat (1,0).
REQ-039 With BINARIZE_EN: pixel 0x81/avg 0x80 -> bin=1; 0x80/0x80 -> bin=0; without macro both -> 0.
REQ-040 Reset asserted with 2 buffered words -> out_valid=0 next cycle, in_ready=1, buffered words never emitted.
